// File: rtl/countdown_timer_ctrl.sv
// Parametrised second-resolution countdown timer with start/pause, auto-reload and
// registered tick/expiry strobes. Define TIMER_WARN_EN to add the low-count warn output.
module countdown_timer_ctrl #(
  parameter int CLK_FREQ = 25000000,
  parameter int CNT_W    = 8,
  parameter int RST_VAL  = 4,
  parameter int WARN_TH  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             start,
  input  logic             pause,
  input  logic             auto_reload,
  output logic [CNT_W-1:0] cur_val,
  output logic             running,
  output logic             expired,
  output logic             tick,
  output logic             done_pulse
`ifdef TIMER_WARN_EN
  ,
  output logic             warn
`endif
);

  localparam int PS_W = $clog2(CLK_FREQ);
  localparam logic [PS_W-1:0]  PS_MAX  = PS_W'(CLK_FREQ - 1);
  localparam logic [CNT_W-1:0] RST_CNT = CNT_W'(RST_VAL);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Reject parameter sets the counter cannot represent.
  if (CLK_FREQ < 2 || WARN_TH < 0 || RST_VAL < 0 ||
      longint'(RST_VAL) >= (longint'(1) << CNT_W)) begin : g_param_check
    $error("countdown_timer_ctrl: illegal parameter set");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cur_q, cur_d;
  logic [CNT_W-1:0] reload_q, reload_d;
  logic [PS_W-1:0]  ps_q, ps_d;
  logic             running_q, running_d;
  logic             expired_q, expired_d;
  logic             tick_q, tick_d;
  logic             done_q, done_d;

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    reload_d = reload_q;
    ps_d     = ps_q;
    tick_d   = 1'b0;
    done_d   = 1'b0;
    if (load) begin
      cur_d    = load_val;
      reload_d = load_val;
      ps_d     = '0;
      state_d  = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (cur_q != '0) begin
              state_d = ST_RUN;
              ps_d    = '0;
            end else begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (ps_q == PS_MAX) begin
            ps_d   = '0;
            tick_d = 1'b1;
            // Last second of the count: either reload in place or stop at zero.
            if (cur_q <= CNT_ONE) begin
              done_d = 1'b1;
              if (auto_reload && reload_q != '0) begin
                cur_d = reload_q;
              end else begin
                cur_d   = '0;
                state_d = ST_DONE;
              end
            end else begin
              cur_d = cur_q - CNT_ONE;
            end
          end else begin
            ps_d = ps_q + PS_W'(1);
          end
          // Expiry to DONE outranks a simultaneous pause request.
          if (pause && state_d == ST_RUN) begin
            state_d = ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (start && !pause) begin
            state_d = ST_RUN;
          end
        end
        ST_DONE: begin
          if (start && reload_q != '0) begin
            cur_d   = reload_q;
            ps_d    = '0;
            state_d = ST_RUN;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
    running_d = (state_d == ST_RUN);
    expired_d = (state_d == ST_DONE);
  end

`ifdef TIMER_WARN_EN
  localparam logic [CNT_W:0] WARN_LIM = (CNT_W + 1)'(WARN_TH);

  logic warn_q, warn_d;

  always_comb begin
    warn_d = (state_d == ST_RUN || state_d == ST_PAUSE) &&
             (cur_d != '0) && ({1'b0, cur_d} <= WARN_LIM);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      warn_q <= 1'b0;
    end else begin
      warn_q <= warn_d;
    end
  end

  assign warn = warn_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cur_q     <= RST_CNT;
      reload_q  <= RST_CNT;
      ps_q      <= '0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
      tick_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      reload_q  <= reload_d;
      ps_q      <= ps_d;
      running_q <= running_d;
      expired_q <= expired_d;
      tick_q    <= tick_d;
      done_q    <= done_d;
    end
  end

  assign cur_val    = cur_q;
  assign running    = running_q;
  assign expired    = expired_q;
  assign tick       = tick_q;
  assign done_pulse = done_q;

endmodule

// File: doc/countdown_timer_ctrl.md
Name: countdown_timer_ctrl

Overview:
- Parametrised second-resolution countdown timer; successor to the fixed 4-bit, 25 MHz single-mode countdown.
- Adds configurable clock rate, counter width and reset value, plus start/pause control, auto-reload mode, and registered expiry/tick strobes.
- Sits between the game/FSM control logic (load, start, pause) and the display/scoring logic (cur_val, strobes).

Parameters:
- CLK_FREQ, 25000000, clk cycles per tick (1 s); minimum 2; benches use 10.
- CNT_W, 8, width of count value.
- RST_VAL, 4, cur_val and reload register value after reset; must be < 2^CNT_W.
- WARN_TH, 3, warning threshold; used only when TIMER_WARN_EN is defined.

Ports:
- clk  in  1  single clock, 25 MHz in system.
- rst  in  1  reset, synchronous, active-high.
- load  in  1  load load_val into cur_val and reload register.
- load_val  in  CNT_W  new starting count.
- start  in  1  begin or resume counting.
- pause  in  1  freeze counting.
- auto_reload  in  1  mode: 1 = restart from reload register on expiry, 0 = stop at 0.
- cur_val  out  CNT_W  current count.
- running  out  1  high in RUN.
- expired  out  1  level, high in DONE.
- tick  out  1  one-cycle pulse per decrement.
- done_pulse  out  1  one-cycle pulse when count reaches 0.

Behaviour:
- All outputs registered; all inputs sampled on posedge clk. Input priority: rst > load > pause > start.
- Reset:
  - state = IDLE; cur_val = RST_VAL; reload register = RST_VAL; prescaler = 0.
  - running, expired, tick, done_pulse = 0.
  - A reset mid-count aborts the count with no strobe.
- Prescaler:
  - Counts 0..CLK_FREQ-1, and only in RUN. Exact tick period is CLK_FREQ cycles.
  - Cleared on load, on reset, and on entry to RUN from IDLE or DONE.
  - Held, not cleared, in PAUSE.
- States:
  - IDLE:
    - start with cur_val != 0 -> RUN.
    - start with cur_val == 0 -> DONE, done_pulse = 1 on the next cycle.
    - pause ignored.
  - RUN:
    - On the cycle prescaler == CLK_FREQ-1: next cycle, tick = 1 and cur_val decrements.
    - If cur_val was 1, done_pulse = 1 in that same next cycle.
    - If auto_reload = 0, state -> DONE.
    - If auto_reload = 1 and reload register != 0, cur_val = reload register, state stays RUN, and done_pulse still fires. cur_val never shows 0 in this case.
    - If auto_reload = 1 and reload register == 0 -> DONE.
    - pause -> PAUSE, next cycle.
  - PAUSE:
    - start -> RUN; the prescaler resumes from its held value.
    - cur_val held; tick and done_pulse never fire.
  - DONE:
    - cur_val = 0; expired = 1.
    - start with reload register != 0 -> cur_val = reload register, prescaler = 0, RUN.
    - start with reload register == 0 -> stays DONE, no strobes.
    - pause ignored.
- load (any state):
  - Next cycle: cur_val = load_val, reload register = load_val, prescaler = 0, state = IDLE.
  - running = 0; expired = 0; pending strobes suppressed.
  - load together with start: load wins, start ignored.
- Arithmetic:
  - Decrement is unsigned. cur_val never wraps below 0.
  - The prescaler is $clog2(CLK_FREQ) bits wide.
- running and expired are derived from the registered state, not decoded combinationally from inputs.

Optional Feature:
- Macro: TIMER_WARN_EN.
- Defined: adds output port warn (1 bit, registered, reset 0).
  - warn = 1 while state is RUN or PAUSE and 0 < cur_val <= WARN_TH; otherwise 0.
  - Updates in the same cycle cur_val updates.
- Undefined: no warn port; no comparator logic.

Test Plan:
- Reset/start (CLK_FREQ=10, CNT_W=8, RST_VAL=4):
  - Reset, then start -> tick every 10 cycles; cur_val 4,3,2,1,0.
  - done_pulse exactly once, coincident with cur_val==0; expired=1 thereafter; running=0.
- Pause:
  - load 5, start, pause asserted 4 cycles after the first tick for 20 cycles, then start -> cur_val holds at 4 during the pause.
  - The next tick arrives 6 cycles after resume (prescaler held, not cleared).
- Auto-reload:
  - auto_reload=1, load 2, start -> sequence 2,1,2,1,...
  - done_pulse on each 1->reload transition, every 20 cycles; expired never asserts.
- Edge cases:
  - load 0, start -> DONE next cycle, done_pulse=1 for one cycle, no tick.
  - Then start in DONE -> remains DONE, no strobes.
- Load while running:
  - load 9 while RUN at cur_val=3 and prescaler=7 -> next cycle cur_val=9, state IDLE, prescaler=0, no tick or done_pulse.
  - load+start in the same cycle -> IDLE.
- Warning (TIMER_WARN_EN defined, WARN_TH=3):
  - load 5, start -> warn rises with cur_val==3, stays high at 2 and 1, and drops to 0 when cur_val==0 (DONE).
